// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Bundles the two requester ports, the shared 8-bit ALU port and
//            the result/status outputs of alu_arbiter.
// Ports    : requester N (N=0,1): IN_reqN, IN_opN[3:0], IN_aN/IN_bN[15:0],
//            OUT_gntN, OUT_doneN
//            ALU side: OUT_data_a/b[7:0], OUT_ALU_OP[3:0], OUT_carry_out,
//            IN_S[7:0], IN_carry_in, IN_zero
//            status: OUT_result[15:0], OUT_zero, OUT_neg, OUT_less_than,
//            OUT_busy
//            modport slave = arbiter view, modport master = environment view.
// Revision : 1.0  initial release
// ============================================================================
interface alu_arbiter_if;
  logic        IN_req0, IN_req1;
  logic [3:0]  IN_op0, IN_op1;
  logic [15:0] IN_a0, IN_b0, IN_a1, IN_b1;
  logic [7:0]  IN_S;
  logic        IN_carry_in;
  logic        IN_zero;
  logic [7:0]  OUT_data_a, OUT_data_b;
  logic [3:0]  OUT_ALU_OP;
  logic        OUT_carry_out;
  logic        OUT_gnt0, OUT_gnt1;
  logic        OUT_done0, OUT_done1;
  logic [15:0] OUT_result;
  logic        OUT_zero, OUT_neg, OUT_less_than;
  logic        OUT_busy;

  modport slave (
    input  IN_req0, IN_req1, IN_op0, IN_op1, IN_a0, IN_b0, IN_a1, IN_b1,
           IN_S, IN_carry_in, IN_zero,
    output OUT_data_a, OUT_data_b, OUT_ALU_OP, OUT_carry_out,
           OUT_gnt0, OUT_gnt1, OUT_done0, OUT_done1,
           OUT_result, OUT_zero, OUT_neg, OUT_less_than, OUT_busy
  );

  modport master (
    output IN_req0, IN_req1, IN_op0, IN_op1, IN_a0, IN_b0, IN_a1, IN_b1,
           IN_S, IN_carry_in, IN_zero,
    input  OUT_data_a, OUT_data_b, OUT_ALU_OP, OUT_carry_out,
           OUT_gnt0, OUT_gnt1, OUT_done0, OUT_done1,
           OUT_result, OUT_zero, OUT_neg, OUT_less_than, OUT_busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter between two requesters sharing an external
//            8-bit ALU. Each 16-bit operation runs as low byte then high byte
//            (IDLE -> LO -> HI -> DONE), one operation every 4 cycles.
// Ports    : IN_clk  - clock, rising edge
//            IN_rst  - asynchronous active-high reset
//            bus     - alu_arbiter_if.slave (requests, ALU port, results)
// Params   : RR_INIT - requester that wins the first contention after reset
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  wire logic     IN_clk,
  input  wire logic     IN_rst,
  alu_arbiter_if.slave  bus
);

  localparam logic [3:0] c_OP_ADD = 4'hA;
  localparam logic [3:0] c_OP_SUB = 4'hB;
  localparam logic [3:0] c_OP_AND = 4'hC;
  localparam logic [3:0] c_OP_OR  = 4'hD;
  localparam logic [3:0] c_OP_CMP = 4'hE;

  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

  state_t      r_state;
  logic        r_last;      // requester served last; the other one wins a tie
  logic        r_owner;
  logic [3:0]  r_op;
  logic [7:0]  r_a_hi, r_b_hi;
  logic [7:0]  r_res_lo, r_res_hi;
  logic        r_zero_lo, r_zero_all, r_lt;

  logic        w_win;
  logic [3:0]  w_op;
  logic [15:0] w_a, w_b;
  logic        w_win_ok, w_op_ok;

  function automatic logic f_op_ok(input logic [3:0] op);
    return (op >= c_OP_ADD) && (op <= c_OP_CMP);
  endfunction

  always_comb begin
    w_win = 1'b0;
    if (bus.IN_req0 && bus.IN_req1) w_win = ~r_last;
    else if (bus.IN_req1)           w_win = 1'b1;
    w_op     = w_win ? bus.IN_op1 : bus.IN_op0;
    w_a      = w_win ? bus.IN_a1  : bus.IN_a0;
    w_b      = w_win ? bus.IN_b1  : bus.IN_b0;
    w_win_ok = f_op_ok(w_op);
    w_op_ok  = f_op_ok(r_op);
  end

  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) begin
      r_state           <= IDLE;
      r_last            <= ~RR_INIT;
      r_owner           <= 1'b0;
      r_op              <= 4'h0;
      r_a_hi            <= 8'h00;
      r_b_hi            <= 8'h00;
      r_res_lo          <= 8'h00;
      r_res_hi          <= 8'h00;
      r_zero_lo         <= 1'b0;
      r_zero_all        <= 1'b0;
      r_lt              <= 1'b0;
      bus.OUT_data_a    <= 8'h00;
      bus.OUT_data_b    <= 8'h00;
      bus.OUT_ALU_OP    <= 4'h0;
      bus.OUT_carry_out <= 1'b0;
      bus.OUT_gnt0      <= 1'b0;
      bus.OUT_gnt1      <= 1'b0;
      bus.OUT_done0     <= 1'b0;
      bus.OUT_done1     <= 1'b0;
      bus.OUT_result    <= 16'h0000;
      bus.OUT_zero      <= 1'b0;
      bus.OUT_neg       <= 1'b0;
      bus.OUT_less_than <= 1'b0;
      bus.OUT_busy      <= 1'b0;
    end else begin
      bus.OUT_gnt0  <= 1'b0;
      bus.OUT_gnt1  <= 1'b0;
      bus.OUT_done0 <= 1'b0;
      bus.OUT_done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.IN_req0 || bus.IN_req1) begin
            r_owner      <= w_win;
            r_op         <= w_op;
            r_a_hi       <= w_a[15:8];
            r_b_hi       <= w_b[15:8];
            bus.OUT_gnt0 <= ~w_win;
            bus.OUT_gnt1 <= w_win;
            bus.OUT_busy <= 1'b1;
            // Unknown opcodes still run the full sequence but never touch the ALU.
            if (w_win_ok) begin
              bus.OUT_data_a    <= w_a[7:0];
              bus.OUT_data_b    <= w_b[7:0];
              bus.OUT_ALU_OP    <= w_op;
              bus.OUT_carry_out <= (w_op == c_OP_SUB) || (w_op == c_OP_CMP);
            end
            r_state <= LO;
          end
        end
        LO: begin
          r_res_lo  <= bus.IN_S;
          r_zero_lo <= bus.IN_zero;
          if (w_op_ok) begin
            bus.OUT_data_a    <= r_a_hi;
            bus.OUT_data_b    <= r_b_hi;
            bus.OUT_ALU_OP    <= r_op;
            // Low-byte carry/borrow chains into the high byte for arithmetic.
            bus.OUT_carry_out <= (r_op == c_OP_AND || r_op == c_OP_OR) ? 1'b0 : bus.IN_carry_in;
          end
          r_state <= HI;
        end
        HI: begin
          r_res_hi          <= bus.IN_S;
          r_zero_all        <= r_zero_lo & bus.IN_zero;
          r_lt              <= (r_op == c_OP_CMP) & ~bus.IN_carry_in;
          bus.OUT_data_a    <= 8'h00;
          bus.OUT_data_b    <= 8'h00;
          bus.OUT_ALU_OP    <= 4'h0;
          bus.OUT_carry_out <= 1'b0;
          r_state           <= DONE;
        end
        DONE: begin
          if (w_op_ok) begin
            bus.OUT_result    <= {r_res_hi, r_res_lo};
            bus.OUT_zero      <= r_zero_all;
            bus.OUT_neg       <= r_res_hi[7];
            bus.OUT_less_than <= r_lt;
          end else begin
            bus.OUT_result    <= 16'h0000;
            bus.OUT_zero      <= 1'b1;
            bus.OUT_neg       <= 1'b0;
            bus.OUT_less_than <= 1'b0;
          end
          bus.OUT_done0 <= ~r_owner;
          bus.OUT_done1 <= r_owner;
          r_last        <= r_owner;
          bus.OUT_busy  <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter with a behavioural 8-bit ALU,
//            a queue of expected results and a done-pulse monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

  logic clk;
  logic rst;
  alu_arbiter_if bus ();

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .IN_clk (clk),
    .IN_rst (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared ALU
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = 9'h000;
    case (bus.OUT_ALU_OP)
      4'hA:       alu_sum = {1'b0, bus.OUT_data_a} + {1'b0, bus.OUT_data_b} + {8'h00, bus.OUT_carry_out};
      4'hB, 4'hE: alu_sum = {1'b0, bus.OUT_data_a} + {1'b0, ~bus.OUT_data_b} + {8'h00, bus.OUT_carry_out};
      4'hC:       alu_sum = {1'b0, bus.OUT_data_a & bus.OUT_data_b};
      4'hD:       alu_sum = {1'b0, bus.OUT_data_a | bus.OUT_data_b};
      default:    alu_sum = 9'h000;
    endcase
    bus.IN_S        = alu_sum[7:0];
    bus.IN_carry_in = alu_sum[8];
    bus.IN_zero     = (alu_sum[7:0] == 8'h00);
  end

  typedef struct {
    logic        owner;
    logic [15:0] res;
    logic        z, n, lt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   g0    = 0;
  int   g1    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      if (bus.OUT_gnt0) g0 = cyc;
      if (bus.OUT_gnt1) g1 = cyc;
      if (bus.OUT_done0 || bus.OUT_done1) begin
        if (q.size() == 0) begin
          check("unexpected_done", {bus.OUT_done1, bus.OUT_done0}, 0);
        end else begin
          e = q.pop_front();
          check("done_owner", {bus.OUT_done1, bus.OUT_done0}, e.owner ? 2'b10 : 2'b01);
          check("result", bus.OUT_result, e.res);
          check("flags", {bus.OUT_zero, bus.OUT_neg, bus.OUT_less_than}, {e.z, e.n, e.lt});
          check("done_latency", cyc - (e.owner ? g1 : g0), 3);
        end
      end
    end
  end

  task automatic set_req(input bit n, input logic v, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    if (n) begin
      bus.IN_req1 = v; bus.IN_op1 = op; bus.IN_a1 = a; bus.IN_b1 = b;
    end else begin
      bus.IN_req0 = v; bus.IN_op0 = op; bus.IN_a0 = a; bus.IN_b0 = b;
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!bus.OUT_busy) begin ok = 1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic do_op(input bit n, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic ez, input logic en, input logic el,
                       input int cin_hi);
    bit   got = 0;
    logic ok;
    q.push_back('{n, er, ez, en, el});
    set_req(n, 1'b1, op, a, b);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (n ? bus.OUT_gnt1 : bus.OUT_gnt0) begin got = 1; break; end
    end
    check("gnt_seen", got, 1);
    if (n) bus.IN_req1 = 1'b0; else bus.IN_req0 = 1'b0;
    ok = (op >= 4'hA) && (op <= 4'hE);
    check("alu_lo", {bus.OUT_data_a, bus.OUT_data_b, bus.OUT_ALU_OP, bus.OUT_carry_out},
          ok ? {a[7:0], b[7:0], op, (op == 4'hB || op == 4'hE)} : 21'h0);
    @(posedge clk); #1;
    check("alu_hi", {bus.OUT_data_a, bus.OUT_data_b, bus.OUT_ALU_OP},
          ok ? {a[15:8], b[15:8], op} : 20'h0);
    if (cin_hi >= 0) check("alu_hi_cin", bus.OUT_carry_out, cin_hi[0]);
    wait_idle();
  endtask

  initial begin
    int  k;
    int  last_g;
    bit  exp_owner;
    bit  got;

    rst = 1'b1;
    set_req(0, 1'b0, 4'h0, 16'h0, 16'h0);
    set_req(1, 1'b0, 4'h0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    check("reset_outs",
          {bus.OUT_data_a, bus.OUT_data_b, bus.OUT_ALU_OP, bus.OUT_carry_out, bus.OUT_gnt0, bus.OUT_gnt1,
           bus.OUT_done0, bus.OUT_done1, bus.OUT_result, bus.OUT_zero, bus.OUT_neg, bus.OUT_less_than,
           bus.OUT_busy}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Both requesters held: expect 0,1,0,1, 4 cycles apart
    q.push_back('{1'b0, 16'h0003, 1'b0, 1'b0, 1'b0});
    q.push_back('{1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0});
    q.push_back('{1'b0, 16'h0003, 1'b0, 1'b0, 1'b0});
    q.push_back('{1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0});
    set_req(0, 1'b1, 4'hA, 16'h0001, 16'h0002);
    set_req(1, 1'b1, 4'hD, 16'h00F0, 16'h0F00);
    k = 0; last_g = 0; exp_owner = 1'b0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(posedge clk); #1;
      if (bus.OUT_gnt0 || bus.OUT_gnt1) begin
        check("rr_order", {bus.OUT_gnt1, bus.OUT_gnt0}, exp_owner ? 2'b10 : 2'b01);
        if (k > 0) check("rr_spacing", cyc - last_g, 4);
        last_g = cyc;
        exp_owner = ~exp_owner;
        k++;
        if (k == 4) begin bus.IN_req0 = 1'b0; bus.IN_req1 = 1'b0; end
      end
    end
    check("rr_grants", k, 4);
    bus.IN_req0 = 1'b0; bus.IN_req1 = 1'b0;
    wait_idle();

    // Directed operations: requester, op, a, b, result, zero, neg, lt, high-byte carry
    do_op(0, 4'hA, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 0, 1);
    do_op(1, 4'hB, 16'h0003, 16'h0005, 16'hFFFE, 0, 1, 0, 0);
    do_op(1, 4'hE, 16'h0003, 16'h0005, 16'hFFFE, 0, 1, 1, 0);
    do_op(0, 4'hE, 16'h1234, 16'h1234, 16'h0000, 1, 0, 0, 1);
    do_op(0, 4'hC, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0, 0);
    do_op(1, 4'hD, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0);
    do_op(0, 4'h3, 16'h1234, 16'h5678, 16'h0000, 1, 0, 0, -1);

    // Reset while in HI: outputs clear at once, no done, held request regranted
    @(negedge clk);
    set_req(0, 1'b1, 4'hB, 16'h8000, 16'h0001);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.OUT_gnt0) begin got = 1; break; end
    end
    check("abort_gnt_seen", got, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_outs",
          {bus.OUT_data_a, bus.OUT_data_b, bus.OUT_ALU_OP, bus.OUT_carry_out, bus.OUT_gnt0, bus.OUT_gnt1,
           bus.OUT_done0, bus.OUT_done1, bus.OUT_result, bus.OUT_zero, bus.OUT_neg, bus.OUT_less_than,
           bus.OUT_busy}, 0);
    q.push_back('{1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("regrant_after_reset", bus.OUT_gnt0, 1);
    bus.IN_req0 = 1'b0;
    wait_idle();

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
